// File: rtl/udp_tx_framer.sv
// Store-and-forward UDP transmit framer: buffers one payload packet, then emits
// a UDP header followed by the buffered bytes. Errored or oversize packets are dropped.
module udp_tx_framer #(
  parameter int MAX_PAYLOAD_BYTES = 1472,
  parameter int ADDR_WIDTH        = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  input  logic [31:0] cfg_source_ip,
  input  logic [31:0] cfg_dest_ip,
  input  logic [15:0] cfg_source_port,
  input  logic [15:0] cfg_dest_port,
  input  logic [7:0]  cfg_ttl,
  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [5:0]  m_udp_ip_dscp,
  output logic [1:0]  m_udp_ip_ecn,
  output logic [7:0]  m_udp_ip_ttl,
  output logic [31:0] m_udp_ip_source_ip,
  output logic [31:0] m_udp_ip_dest_ip,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  output logic [15:0] m_udp_length,
  output logic [15:0] m_udp_checksum,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [15:0] frames_sent,
  output logic [15:0] frames_dropped
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] MAX_PTR = PTR_W'(MAX_PAYLOAD_BYTES);

  typedef enum logic [1:0] {ST_FILL, ST_HDR, ST_PAYLOAD} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [15:0]       rd_ptr_q, rd_ptr_d;
  logic [15:0]       len_q, len_d;
  logic              overflow_q, overflow_d;
  logic              ram_vld_q, ram_vld_d;
  logic              ram_last_q, ram_last_d;
  logic              out_vld_q, out_vld_d;
  logic              out_last_q, out_last_d;
  logic [15:0]       sent_q, sent_d;
  logic [15:0]       dropped_q, dropped_d;

  logic [31:0]       src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
  logic [15:0]       src_port_q, src_port_d, dst_port_q, dst_port_d;
  logic [7:0]        ttl_q, ttl_d;
  logic [7:0]        out_data_q, out_data_d;
  logic [7:0]        ram_data_q;
  logic [7:0]        mem [0:MAX_PAYLOAD_BYTES-1];

  logic in_hs, at_max, mem_we, cfg_latch, out_hs, ram_move, rd_issue, drop;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    len_d      = len_q;
    overflow_d = overflow_q;
    ram_vld_d  = ram_vld_q;
    ram_last_d = ram_last_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    sent_d     = sent_q;
    dropped_d  = dropped_q;
    out_data_d = out_data_q;

    in_hs     = s_axis_tvalid && (state_q == ST_FILL);
    at_max    = (wr_ptr_q == MAX_PTR);
    mem_we    = in_hs && !at_max;
    cfg_latch = in_hs && (wr_ptr_q == '0) && !overflow_q;
    drop      = s_axis_tuser || overflow_q || at_max;
    out_hs    = out_vld_q && m_axis_tready;
    // Two-entry read pipeline (RAM register + output register) keeps full
    // throughput while never overwriting a byte that is still held.
    ram_move  = ram_vld_q && (!out_vld_q || m_axis_tready);
    rd_issue  = (state_q == ST_PAYLOAD) && (rd_ptr_q < len_q) && (!ram_vld_q || ram_move);

    src_ip_d   = cfg_latch ? cfg_source_ip   : src_ip_q;
    dst_ip_d   = cfg_latch ? cfg_dest_ip     : dst_ip_q;
    src_port_d = cfg_latch ? cfg_source_port : src_port_q;
    dst_port_d = cfg_latch ? cfg_dest_port   : dst_port_q;
    ttl_d      = cfg_latch ? cfg_ttl         : ttl_q;

    if (rd_issue) begin
      rd_ptr_d   = rd_ptr_q + 16'd1;
      ram_vld_d  = 1'b1;
      ram_last_d = (rd_ptr_q == len_q - 16'd1);
    end else if (ram_move) begin
      ram_vld_d  = 1'b0;
    end

    if (ram_move) begin
      out_vld_d  = 1'b1;
      out_last_d = ram_last_q;
      out_data_d = ram_data_q;
    end else if (out_hs) begin
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
    end

    case (state_q)
      ST_FILL: begin
        if (in_hs) begin
          if (at_max) overflow_d = 1'b1;
          else        wr_ptr_d   = wr_ptr_q + 1'b1;
          if (s_axis_tlast) begin
            if (drop) begin
              wr_ptr_d   = '0;
              overflow_d = 1'b0;
              dropped_d  = dropped_q + 16'd1;
            end else begin
              len_d   = 16'(wr_ptr_q) + 16'd1;
              state_d = ST_HDR;
            end
          end
        end
      end
      ST_HDR: begin
        if (m_udp_hdr_ready) begin
          rd_ptr_d = '0;
          state_d  = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (out_hs && out_last_q) begin
          sent_d     = sent_q + 16'd1;
          wr_ptr_d   = '0;
          out_vld_d  = 1'b0;
          out_last_d = 1'b0;
          ram_vld_d  = 1'b0;
          state_d    = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      len_q      <= '0;
      overflow_q <= 1'b0;
      ram_vld_q  <= 1'b0;
      ram_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      sent_q     <= '0;
      dropped_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      overflow_q <= overflow_d;
      ram_vld_q  <= ram_vld_d;
      ram_last_q <= ram_last_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      sent_q     <= sent_d;
      dropped_q  <= dropped_d;
    end
  end

  always_ff @(posedge clk) begin
    src_ip_q   <= src_ip_d;
    dst_ip_q   <= dst_ip_d;
    src_port_q <= src_port_d;
    dst_port_q <= dst_port_d;
    ttl_q      <= ttl_d;
    out_data_q <= out_data_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= s_axis_tdata;
    if (rd_issue) ram_data_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
  end

  assign s_axis_tready      = (state_q == ST_FILL);
  assign m_udp_hdr_valid    = (state_q == ST_HDR);
  assign m_udp_ip_dscp      = 6'd0;
  assign m_udp_ip_ecn       = 2'd0;
  assign m_udp_ip_ttl       = ttl_q;
  assign m_udp_ip_source_ip = src_ip_q;
  assign m_udp_ip_dest_ip   = dst_ip_q;
  assign m_udp_source_port  = src_port_q;
  assign m_udp_dest_port    = dst_port_q;
  assign m_udp_length       = len_q + 16'd8;
  assign m_udp_checksum     = 16'd0;
  assign m_axis_tdata       = out_data_q;
  assign m_axis_tvalid      = out_vld_q;
  assign m_axis_tlast       = out_vld_q && out_last_q;
  assign m_axis_tuser       = 1'b0;
  assign frames_sent        = sent_q;
  assign frames_dropped     = dropped_q;

endmodule
